ofdm_qam_mapper: RTL
====================

Name: ofdm_qam_mapper

Overview:
- Upstream neighbour of the subcarrier-reorder stage in the OFDM transmit chain.
- Accepts a byte stream and splits it into bit groups per the selected modulation.
- Gray-maps each group to a signed complex symbol {I[31:16], Q[15:0]} and emits exactly SYM_PER_FRAME symbols per OFDM frame over a valid/ready handshake.

Parameters:
- SYM_PER_FRAME, 62, data symbols per OFDM frame (active subcarriers)
- AMP_BPSK, 16384, BPSK amplitude (Q1.14)
- AMP_QPSK, 11585, QPSK per-axis amplitude (Q1.14)
- D_QAM16, 5181, 16-QAM unit level; outer level = 3*D_QAM16 = 15543

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mode  in  2  00 BPSK, 01 QPSK, 10 16-QAM, 11 reserved (treated as QPSK)
- data_in  in  8  input byte
- valid_in  in  1  data_in valid
- ready_out  out  1  byte accepted when valid_in && ready_out
- data_out  out  32  signed symbol {I,Q}, two's complement
- valid_out  out  1  data_out valid
- ready_in  in  1  downstream ready
- frame_start  out  1  qualifies data_out as symbol 0 of a frame
- sym_cnt  out  6  index of the symbol on data_out (0..SYM_PER_FRAME-1)

Behaviour:
- Reset (asynchronous, immediate, also mid-frame):
  - valid_out=0, data_out=0, frame_start=0, sym_cnt=0.
  - Bit buffer is empty (bits_left=0); latched mode is QPSK.
  - Any partial frame is abandoned.
  - After release, the first accepted byte starts a new frame.
- k = bits per symbol: 1, 2 or 4 from the latched mode.
- Latched mode is sampled only when the byte that starts a frame is loaded (sym_cnt pointer=0, bits_left=0). Changes to mode mid-frame are ignored until the next frame.
- ready_out = (bits_left==0), combinational. It has no dependency on valid_in.
- Load: valid_in && ready_out loads data_in into the 8-bit buffer and sets bits_left=8. No symbol is produced in the load cycle.
- Emit:
  - Condition: (!valid_out || ready_in) && bits_left>=k.
  - Take the top k bits (MSB first), shift left by k, bits_left -= k.
  - Register the mapped symbol into data_out with valid_out=1.
- Latency: byte accepted in cycle t gives its first symbol valid at t+1.
- Throughput with ready_in held high: 8/k symbols per 8/k+1 cycles.
- Hold: while valid_out && !ready_in, data_out, frame_start and sym_cnt are stable and no emit occurs.
- Drain: if valid_out && ready_in and there is no emit condition, valid_out drops to 0 in the next cycle.
- Frame counter:
  - Increments on each emit; frame_start=1 exactly when the emitted symbol has index 0.
  - After emitting index SYM_PER_FRAME-1, the counter wraps to 0 and residual bits_left is forced to 0 (discarded). Every frame therefore starts byte-aligned.
  - Per frame: QPSK uses 16 bytes (last 4 bits dropped), BPSK 8 bytes (last 2 dropped), 16-QAM 31 bytes (exact).
- Mapping, where bit 0 maps to + and bit 1 maps to -:
  - BPSK: I = b ? -AMP_BPSK : +AMP_BPSK, Q = 0.
  - QPSK: bits b1b0; I from b1, Q from b0, amplitude AMP_QPSK.
  - 16-QAM: bits b3b2b1b0; I from b3b2, Q from b1b0.
  - 16-QAM Gray levels: 00->-3D, 01->-D, 11->+D, 10->+3D.
- Arithmetic: all levels are 16-bit signed constants; no saturation is required; the 3*D_QAM16 product is formed at elaboration.

Optional Feature:
- Macro: MAPPER_SCRAMBLER_EN.
- With the macro defined:
  - A 7-bit additive scrambler is applied to each bit before mapping: s = x[6]^x[3], bit_out = bit^s, x <= {x[5:0], s}.
  - x is seeded to 7'b1111111 at reset and at every frame start, before the first bit of the frame.
  - The first 8 scrambler outputs are 0,0,0,0,1,1,1,0.
  - Only bits actually mapped advance x; discarded residual bits do not.
- Without the macro, bits map directly and no scrambler state exists.

Test Plan:
- QPSK, byte 0x1B, ready_in=1 -> 4 symbols: 0x2D412D41, 0x2D41D2BF, 0xD2BF2D41, 0xD2BFD2BF. First symbol has frame_start=1, sym_cnt=0, and is valid 1 cycle after the load.
- 16-QAM, byte 0xB4 -> 0x3CB7143D, then 0xEBC3C349.
- BPSK, 8 bytes of 0xFF -> 62 symbols of 0xC0000000. The last 2 bits of byte 8 are discarded, and the next byte starts sym_cnt=0 with frame_start=1.
- Backpressure: QPSK, ready_in low for 5 cycles mid-byte -> data_out/valid_out stable, ready_out=0, no symbol lost or duplicated. Release yields the remaining symbols in order.
- Mode change: set mode=10 at sym_cnt=30 of a QPSK frame -> remaining symbols of that frame stay QPSK and the next frame is 16-QAM (31 bytes). Assert rst_n low mid-frame -> valid_out=0 the same cycle, and the next frame starts at sym_cnt=0.
- MAPPER_SCRAMBLER_EN, BPSK, byte 0x00 -> symbols +,+,+,+,-,-,-,+ (0x40000000 x4, 0xC0000000 x3, 0x40000000).

Source files
------------

// File: rtl/ofdm_qam_mapper.sv
// ofdm_qam_mapper
// Splits an input byte stream into 1/2/4-bit groups (BPSK / QPSK / 16-QAM),
// Gray-maps each group to a signed complex symbol {I[31:16], Q[15:0]} and
// emits exactly SYM_PER_FRAME symbols per OFDM frame.
//
// Optional build macro: MAPPER_SCRAMBLER_EN
//   When defined, a 7-bit additive scrambler (s = x[6]^x[3]) whitens every
//   mapped bit. It is reseeded to 7'h7F at reset and at every frame start.
//   When undefined, bits map directly and no scrambler state exists.
//
// Handshake rules (both ports):
//   A transfer happens on a rising edge where valid and ready are both high.
//   A source holds its payload stable while valid is high and ready is low.
//   ready_out is combinational, equals (bits_left == 0) and never looks at
//   valid_in. valid_out never drops without a transfer.

module ofdm_qam_mapper #(
  parameter int SYM_PER_FRAME = 62,
  parameter int AMP_BPSK      = 16384,
  parameter int AMP_QPSK      = 11585,
  parameter int D_QAM16       = 5181
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic [31:0] data_out,
  output logic        valid_out,
  input  logic        ready_in,
  output logic        frame_start,
  output logic [5:0]  sym_cnt
);

  // Constellation levels, all 16-bit two's complement, fixed at elaboration.
  localparam logic [15:0] BPSK_POS = 16'(AMP_BPSK);
  localparam logic [15:0] BPSK_NEG = 16'(-AMP_BPSK);
  localparam logic [15:0] QPSK_POS = 16'(AMP_QPSK);
  localparam logic [15:0] QPSK_NEG = 16'(-AMP_QPSK);
  localparam logic [15:0] QAM_P1   = 16'(D_QAM16);
  localparam logic [15:0] QAM_N1   = 16'(-D_QAM16);
  localparam logic [15:0] QAM_P3   = 16'(3 * D_QAM16);
  localparam logic [15:0] QAM_N3   = 16'(-3 * D_QAM16);

  localparam logic [5:0]  LAST_IDX = 6'(SYM_PER_FRAME - 1);

  // Mode encodings as stored in the latched mode register.
  localparam logic [1:0]  MODE_BPSK  = 2'b00;
  localparam logic [1:0]  MODE_QPSK  = 2'b01;
  localparam logic [1:0]  MODE_QAM16 = 2'b10;

  logic [7:0] bit_buf;    // unconsumed bits, MSB first
  logic [3:0] bits_left;  // valid bits remaining in bit_buf (0..8)
  logic [1:0] mode_lat;   // modulation for the current frame
  logic [5:0] sym_ptr;    // index the next emitted symbol will carry
  logic [3:0] k;          // bits per symbol for the latched mode
  logic       load;
  logic       emit;
  logic       frame_end;  // the symbol being emitted closes the frame
  logic [3:0] grp;        // top four buffer bits after optional scrambling
  logic [31:0] sym_next;

  // Gray level for one 16-QAM axis: 00->-3D, 01->-D, 11->+D, 10->+3D.
  function automatic logic [15:0] qam_level(input logic [1:0] b);
    logic [15:0] lvl;
    case (b)
      2'b00:   lvl = QAM_N3;
      2'b01:   lvl = QAM_N1;
      2'b11:   lvl = QAM_P1;
      default: lvl = QAM_P3;
    endcase
    return lvl;
  endfunction

  // Bits per symbol follow the latched mode, never the live mode input.
  always_comb begin
    case (mode_lat)
      MODE_BPSK:  k = 4'd1;
      MODE_QAM16: k = 4'd4;
      default:    k = 4'd2;
    endcase
  end

  // Handshake decode; load and emit are mutually exclusive because load
  // needs an empty buffer and emit needs at least one bit.
  always_comb begin
    ready_out = (bits_left == 4'd0);
    load      = valid_in && ready_out;
    emit      = (!valid_out || ready_in) && (bits_left >= k);
    frame_end = (sym_ptr == LAST_IDX);
  end

`ifdef MAPPER_SCRAMBLER_EN
  logic [6:0] scr_x;
  logic [6:0] scr_x_next;
  logic [6:0] scr_step [0:4];
  logic [3:0] scr_bits;

  // Run the scrambler four steps ahead; only the first k steps are used.
  always_comb begin
    scr_step[0] = scr_x;
    scr_bits    = 4'd0;
    for (int i = 0; i < 4; i++) begin
      scr_bits[3-i]  = scr_step[i][6] ^ scr_step[i][3];
      scr_step[i+1]  = {scr_step[i][5:0], scr_bits[3-i]};
    end
    grp = bit_buf[7:4] ^ scr_bits;
    case (k)
      4'd1:    scr_x_next = scr_step[1];
      4'd4:    scr_x_next = scr_step[4];
      default: scr_x_next = scr_step[2];
    endcase
  end

  // Scrambler advances only on mapped bits; reseeds when a frame closes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scr_x <= 7'h7F;
    end else if (emit) begin
      scr_x <= frame_end ? 7'h7F : scr_x_next;
    end
  end
`else
  // Without scrambling the group is simply the top of the buffer.
  always_comb begin
    grp = bit_buf[7:4];
  end
`endif

  // Map the leading group to {I, Q}; bit 0 maps to +, bit 1 maps to -.
  always_comb begin
    case (mode_lat)
      MODE_BPSK:  sym_next = {(grp[3] ? BPSK_NEG : BPSK_POS), 16'd0};
      MODE_QAM16: sym_next = {qam_level(grp[3:2]), qam_level(grp[1:0])};
      default:    sym_next = {(grp[3] ? QPSK_NEG : QPSK_POS),
                              (grp[2] ? QPSK_NEG : QPSK_POS)};
    endcase
  end

  // Bit buffer, frame pointer and mode latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_buf   <= 8'd0;
      bits_left <= 4'd0;
      mode_lat  <= MODE_QPSK;
      sym_ptr   <= 6'd0;
    end else if (load) begin
      bit_buf   <= data_in;
      bits_left <= 4'd8;
      // Mode is captured only by the byte that opens a frame; reserved
      // encoding 11 behaves as QPSK.
      if (sym_ptr == 6'd0) begin
        mode_lat <= (mode == 2'b11) ? MODE_QPSK : mode;
      end
    end else if (emit) begin
      bit_buf <= bit_buf << k;
      if (frame_end) begin
        // Residual bits are dropped so every frame starts byte-aligned.
        sym_ptr   <= 6'd0;
        bits_left <= 4'd0;
      end else begin
        sym_ptr   <= sym_ptr + 6'd1;
        bits_left <= bits_left - k;
      end
    end
  end

  // Output register: load a new symbol on emit, drop valid once drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= 32'd0;
      valid_out   <= 1'b0;
      frame_start <= 1'b0;
      sym_cnt     <= 6'd0;
    end else if (emit) begin
      data_out    <= sym_next;
      valid_out   <= 1'b1;
      frame_start <= (sym_ptr == 6'd0);
      sym_cnt     <= sym_ptr;
    end else if (valid_out && ready_in) begin
      valid_out   <= 1'b0;
    end
  end

endmodule
